// File: rtl/inst_loop_seq.sv
// Purpose: instruction-address sequencer with up to three nested hardware loops (loop1 innermost).
// Latency: one cycle from start_i/step_i/clr_i to the registered pc_o, counters, busy_o and done_o.
// Backpressure: step_i gates PC advance in RUN; with step_i low, pc_o and counters hold.
module inst_loop_seq #(
  parameter int InstMemDepth     = 32,
  parameter int InstMemAddrWidth = $clog2(InstMemDepth)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        clr_i,
  input  logic                        step_i,
  input  logic [1:0]                  loop_mode_i,
  input  logic [InstMemAddrWidth-1:0] jump_addr1_i,
  input  logic [InstMemAddrWidth-1:0] jump_addr2_i,
  input  logic [InstMemAddrWidth-1:0] jump_addr3_i,
  input  logic [InstMemAddrWidth-1:0] end_addr1_i,
  input  logic [InstMemAddrWidth-1:0] end_addr2_i,
  input  logic [InstMemAddrWidth-1:0] end_addr3_i,
  input  logic [InstMemAddrWidth-1:0] count1_i,
  input  logic [InstMemAddrWidth-1:0] count2_i,
  input  logic [InstMemAddrWidth-1:0] count3_i,
  output logic [InstMemAddrWidth-1:0] pc_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [InstMemAddrWidth-1:0] loop_cnt1_o,
  output logic [InstMemAddrWidth-1:0] loop_cnt2_o,
  output logic [InstMemAddrWidth-1:0] loop_cnt3_o
);

  localparam int W = InstMemAddrWidth;
  localparam logic [W-1:0] LastPc = W'(InstMemDepth - 1);

  typedef enum logic {Idle, Run} state_e;

  state_e       state_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] cnt_q [3];
  logic         done_q;

  logic [W-1:0] jump_a  [3];
  logic [W-1:0] end_a   [3];
  logic [W-1:0] count_a [3];
  logic [W-1:0] end_last;
  int           num_loops;

  logic [W-1:0] pc_nxt;
  logic [W-1:0] cnt_nxt [3];
  logic         jumped;
  logic         finish;

  assign jump_a[0]  = jump_addr1_i;
  assign jump_a[1]  = jump_addr2_i;
  assign jump_a[2]  = jump_addr3_i;
  assign end_a[0]   = end_addr1_i;
  assign end_a[1]   = end_addr2_i;
  assign end_a[2]   = end_addr3_i;
  assign count_a[0] = count1_i;
  assign count_a[1] = count2_i;
  assign count_a[2] = count3_i;

  // A count of 0 behaves as 1; compare one bit wider so cnt+1 cannot wrap.
  function automatic logic exhausted(input logic [W-1:0] cnt, input logic [W-1:0] lim);
    logic [W:0] c1;
    logic [W:0] l1;
    c1 = {1'b0, cnt} + (W+1)'(1);
    l1 = (lim == '0) ? (W+1)'(1) : {1'b0, lim};
    return c1 >= l1;
  endfunction

  // Decode the number of active loops and the outermost loop's end address.
  always_comb begin
    num_loops = 3;
    end_last  = end_addr3_i;
    case (loop_mode_i)
      2'd0: begin num_loops = 1; end_last = end_addr1_i; end
      2'd1: begin num_loops = 2; end_last = end_addr2_i; end
      default: begin num_loops = 3; end_last = end_addr3_i; end
    endcase
  end

  // Scan loops inner to outer: first non-exhausted loop ending here jumps; exhausted ones reset.
  always_comb begin
    pc_nxt = pc_q + W'(1);
    jumped = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cnt_nxt[k] = cnt_q[k];
    end
    for (int k = 0; k < 3; k++) begin
      if (!jumped && (k < num_loops) && (pc_q == end_a[k])) begin
        if (!exhausted(cnt_q[k], count_a[k])) begin
          pc_nxt     = jump_a[k];
          cnt_nxt[k] = cnt_q[k] + W'(1);
          jumped     = 1'b1;
        end else begin
          cnt_nxt[k] = '0;
        end
      end
    end
    finish = !jumped && ((pc_q == end_last) || (pc_q == LastPc));
  end

  // Sequencer state: abort beats start/step; finishing returns to IDLE with a done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      pc_q    <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      if (clr_i) begin
        state_q <= Idle;
        pc_q    <= '0;
        for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
      end else begin
        case (state_q)
          Idle: begin
            if (start_i) begin
              state_q <= Run;
              pc_q    <= '0;
              for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
            end
          end
          Run: begin
            if (step_i) begin
              if (finish) begin
                state_q <= Idle;
                done_q  <= 1'b1;
                pc_q    <= '0;
                for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
              end else begin
                pc_q <= pc_nxt;
                for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_nxt[k];
              end
            end
          end
          default: state_q <= Idle;
        endcase
      end
    end
  end

  assign pc_o        = pc_q;
  assign busy_o      = (state_q == Run);
  assign done_o      = done_q;
  assign loop_cnt1_o = cnt_q[0];
  assign loop_cnt2_o = cnt_q[1];
  assign loop_cnt3_o = cnt_q[2];

endmodule

// File: tb/tb_inst_loop_seq.sv
module tb_inst_loop_seq;

  localparam int W = 5;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         clr_i = 1'b0;
  logic         step_i = 1'b0;
  logic [1:0]   loop_mode_i = '0;
  logic [W-1:0] jump_addr1_i = '0, jump_addr2_i = '0, jump_addr3_i = '0;
  logic [W-1:0] end_addr1_i = '0, end_addr2_i = '0, end_addr3_i = '0;
  logic [W-1:0] count1_i = '0, count2_i = '0, count3_i = '0;
  logic [W-1:0] pc_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] loop_cnt1_o, loop_cnt2_o, loop_cnt3_o;

  int errors = 0;
  int checks = 0;

  inst_loop_seq #(.InstMemDepth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clr_i(clr_i), .step_i(step_i),
    .loop_mode_i(loop_mode_i),
    .jump_addr1_i(jump_addr1_i), .jump_addr2_i(jump_addr2_i), .jump_addr3_i(jump_addr3_i),
    .end_addr1_i(end_addr1_i), .end_addr2_i(end_addr2_i), .end_addr3_i(end_addr3_i),
    .count1_i(count1_i), .count2_i(count2_i), .count3_i(count3_i),
    .pc_o(pc_o), .busy_o(busy_o), .done_o(done_o),
    .loop_cnt1_o(loop_cnt1_o), .loop_cnt2_o(loop_cnt2_o), .loop_cnt3_o(loop_cnt3_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] mode;
    int j1, e1, c1, j2, e2, c2, j3, e3, c3;
    int n;
    int pc [20];
    int cnt1 [20];
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_cfg(input int idx);
    loop_mode_i  = vecs[idx].mode;
    jump_addr1_i = W'(vecs[idx].j1); end_addr1_i = W'(vecs[idx].e1); count1_i = W'(vecs[idx].c1);
    jump_addr2_i = W'(vecs[idx].j2); end_addr2_i = W'(vecs[idx].e2); count2_i = W'(vecs[idx].c2);
    jump_addr3_i = W'(vecs[idx].j3); end_addr3_i = W'(vecs[idx].e3); count3_i = W'(vecs[idx].c3);
  endtask

  // Runs one vector from start to done; optionally stalls at entry hold_idx with a stray start pulse.
  task automatic run_vec(input int idx, input int hold_idx, input int hold_len);
    apply_cfg(idx);
    start_i = 1'b1;
    step_i  = 1'b1;
    tick();
    start_i = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), int'(busy_o), 1);
    for (int i = 0; i < vecs[idx].n; i++) begin
      chk($sformatf("v%0d pc[%0d]", idx, i), int'(pc_o), vecs[idx].pc[i]);
      chk($sformatf("v%0d cnt1[%0d]", idx, i), int'(loop_cnt1_o), vecs[idx].cnt1[i]);
      chk($sformatf("v%0d done_low[%0d]", idx, i), int'(done_o), 0);
      if (i == hold_idx) begin
        step_i = 1'b0;
        for (int h = 0; h < hold_len; h++) begin
          start_i = (h == 1);
          tick();
          chk($sformatf("v%0d hold_pc[%0d]", idx, h), int'(pc_o), vecs[idx].pc[i]);
          chk($sformatf("v%0d hold_busy[%0d]", idx, h), int'(busy_o), 1);
        end
        start_i = 1'b0;
        step_i  = 1'b1;
      end
      tick();
    end
    chk($sformatf("v%0d busy_end", idx), int'(busy_o), 0);
    chk($sformatf("v%0d done_pulse", idx), int'(done_o), 1);
    chk($sformatf("v%0d cnt1_end", idx), int'(loop_cnt1_o), 0);
    tick();
    chk($sformatf("v%0d done_clear", idx), int'(done_o), 0);
    step_i = 1'b0;
  endtask

  initial begin
    // 0: single loop, three passes over 2..4
    vecs[0] = '{mode: 2'd0, j1: 2, e1: 4, c1: 3, j2: 0, e2: 0, c2: 0, j3: 0, e3: 0, c3: 0, n: 11,
      pc:   '{0,1,2,3,4,2,3,4,2,3,4, 0,0,0,0,0,0,0,0,0},
      cnt1: '{0,0,0,0,0,1,1,1,2,2,2, 0,0,0,0,0,0,0,0,0}};
    // 1: two nested loops
    vecs[1] = '{mode: 2'd1, j1: 1, e1: 2, c1: 2, j2: 0, e2: 3, c2: 2, j3: 0, e3: 0, c3: 0, n: 12,
      pc:   '{0,1,2,1,2,3,0,1,2,1,2,3, 0,0,0,0,0,0,0,0},
      cnt1: '{0,0,0,1,1,0,0,0,0,1,1,0, 0,0,0,0,0,0,0,0}};
    // 2: count of zero means a single pass, no jump
    vecs[2] = '{mode: 2'd0, j1: 1, e1: 3, c1: 0, j2: 0, e2: 0, c2: 0, j3: 0, e3: 0, c3: 0, n: 4,
      pc:   '{0,1,2,3, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0},
      cnt1: '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
    // 3: three nested loops (mode 2)
    vecs[3] = '{mode: 2'd2, j1: 1, e1: 1, c1: 2, j2: 0, e2: 2, c2: 2, j3: 0, e3: 3, c3: 2, n: 18,
      pc:   '{0,1,1,2,0,1,1,2,3, 0,1,1,2,0,1,1,2,3, 0,0},
      cnt1: '{0,0,1,0,0,0,1,0,0, 0,0,1,0,0,0,1,0,0, 0,0}};
    // 4: jump past the outer end; finishes at the last memory address instead of wrapping
    vecs[4] = '{mode: 2'd0, j1: 28, e1: 2, c1: 2, j2: 0, e2: 0, c2: 0, j3: 0, e3: 0, c3: 0, n: 7,
      pc:   '{0,1,2,28,29,30,31, 0,0,0,0,0,0,0,0,0,0,0,0,0},
      cnt1: '{0,0,0,1,1,1,1, 0,0,0,0,0,0,0,0,0,0,0,0,0}};

    tick();
    tick();
    rst_i = 1'b0;
    chk("reset_pc", int'(pc_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    chk("reset_cnt", int'({loop_cnt1_o, loop_cnt2_o, loop_cnt3_o}), 0);

    for (int v = 0; v < 5; v++) begin
      run_vec(v, -1, 0);
      tick();
    end

    // Stall three cycles at pc=3 with a start pulse during RUN
    run_vec(0, 3, 3);
    tick();

    // Abort at pc=4
    apply_cfg(0);
    start_i = 1'b1;
    step_i  = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("clr_pre_pc", int'(pc_o), 4);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_busy", int'(busy_o), 0);
    chk("clr_pc", int'(pc_o), 0);
    chk("clr_done", int'(done_o), 0);
    tick();
    chk("clr_done_after", int'(done_o), 0);
    chk("clr_stays_idle", int'(busy_o), 0);
    step_i = 1'b0;

    // Reset mid-RUN in the two-loop setup, then restart
    apply_cfg(1);
    start_i = 1'b1;
    step_i  = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("rst_pre_pc", int'(pc_o), 1);
    chk("rst_pre_cnt2", int'(loop_cnt2_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_pc", int'(pc_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_cnt", int'({loop_cnt1_o, loop_cnt2_o, loop_cnt3_o}), 0);
    step_i = 1'b0;
    tick();
    run_vec(1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_loop_seq.md
INST_LOOP_SEQ -- requirements
Module: inst_loop_seq

Interface
REQ-001 SHALL have parameter InstMemDepth, default 32, instruction memory depth.
REQ-002 SHALL have parameter InstMemAddrWidth, default $clog2(InstMemDepth), PC and loop field width (W).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  start pulse from the CSR block.
REQ-006 SHALL have port clr_i  input  1  synchronous abort pulse.
REQ-007 SHALL have port step_i  input  1  advance PC this cycle when RUN.
REQ-008 SHALL have port loop_mode_i  input  2  active loops: 0=1 loop, 1=2 loops, 2 or 3=3 loops.
REQ-009 SHALL have ports jump_addr{1,2,3}_i  input  W each  loop restart addresses; loop1 is innermost.
REQ-010 SHALL have ports end_addr{1,2,3}_i  input  W each  loop end addresses.
REQ-011 SHALL have ports count{1,2,3}_i  input  W each  iteration counts.
REQ-012 SHALL have port pc_o  output  W  current instruction address.
REQ-013 SHALL have port busy_o  output  1  high in RUN.
REQ-014 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-015 SHALL have ports loop_cnt{1,2,3}_o  output  W each  current iteration counters.

Function
REQ-016 SHALL implement FSM states IDLE and RUN.
REQ-017 SHALL, in IDLE, on start_i=1, enter RUN next cycle with pc_o=0 and all counters at 0; busy_o high from that cycle.
REQ-018 SHALL ignore start_i while in RUN.
REQ-019 SHALL hold pc_o and counters in RUN when step_i=0.
REQ-020 SHALL treat a count of 0 as 1; loop k is exhausted when cnt_k+1 >= max(count_k,1).
REQ-021 SHALL, on a step in RUN, scan k=1..L (L = active loops) in order: for pc_o==end_k, if not exhausted, set pc_o=jump_k, increment cnt_k, and stop scanning; if exhausted, clear cnt_k and continue.
REQ-022 SHALL leave counters of loops outer to the jumping loop unchanged.
REQ-023 SHALL, when no jump occurs and pc_o==end_L, finish: enter IDLE, pulse done_o for one cycle, and clear the counters.
REQ-024 SHALL, when no jump and no finish occurs, set pc_o=pc_o+1.
REQ-025 SHALL, if pc_o==InstMemDepth-1 and no jump or finish applies, finish as in REQ-023 rather than wrap.
REQ-026 SHALL require loop configuration inputs to be stable during RUN; they are sampled live.
REQ-027 SHALL, on clr_i=1, enter IDLE next cycle with pc_o=0, counters 0, and no done_o pulse; clr_i takes priority over start_i and step_i.
REQ-028 SHALL register all outputs, with no combinational input-to-output paths.

Reset
REQ-029 SHALL, while rst_i=1 at a clock edge, force IDLE with pc_o=0, busy_o=0, done_o=0 and loop_cnt*_o=0; reset has priority over all inputs, including mid-RUN.

Verification
REQ-030 mode=0, jump1=2, end1=4, count1=3, step_i held at 1, pulse start -> pc_o is 0,1,2,3,4,2,3,4,2,3,4, then IDLE with one done_o pulse.
REQ-031 mode=1, jump1=1, end1=2, count1=2, jump2=0, end2=3, count2=2 -> pc_o is 0,1,2,1,2,3,0,1,2,1,2,3, then done_o.
REQ-032 mode=0, end1=3, count1=0 -> pc_o is 0,1,2,3, then done_o, with no jump.
REQ-033 Test of REQ-030 with step_i=0 for 3 cycles at pc_o=3, and start_i pulsed mid-RUN -> pc_o holds at 3 and the sequence is otherwise unchanged.
REQ-034 clr_i at pc_o=4 in the REQ-030 setup -> busy_o=0 and pc_o=0 next cycle, with no done_o.
REQ-035 rst_i asserted mid-RUN in the REQ-031 setup -> all outputs 0 next cycle; a subsequent start restarts from pc_o=0.
